// File: rtl/jt12_mix_n_if.sv
// jt12_mix_n_if -- bus bundle for the N-channel gain mixer.
//
// Signals (direction seen from the mixer, i.e. the slave modport):
//   cen        in   clock enable for all mixer state
//   sample     in   start-of-mix strobe (qualified by cen)
//   din        in   NCH packed signed samples, channel k at [k*WIN +: WIN]
//   gain_we    in   gain register write strobe (not qualified by cen)
//   gain_addr  in   channel index for the gain write
//   gain_din   in   gain value, unsigned, 4 fractional bits (0x10 = unity)
//   dout       out  signed mixed sample, held between updates
//   dout_valid out  one-clk pulse when dout updates
//   clip       out  high when the current dout was saturated
//   busy       out  high while a mix is in progress
//   drop       out  sticky: a sample strobe arrived while busy
interface jt12_mix_n_if #(
    parameter int NCH  = 4,
    parameter int WIN  = 16,
    parameter int GW   = 8,
    parameter int WOUT = 16
);
    logic                   cen;
    logic                   sample;
    logic [NCH*WIN-1:0]     din;
    logic                   gain_we;
    logic [3:0]             gain_addr;
    logic [GW-1:0]          gain_din;
    logic signed [WOUT-1:0] dout;
    logic                   dout_valid;
    logic                   clip;
    logic                   busy;
    logic                   drop;

    modport master (
        output cen, sample, din, gain_we, gain_addr, gain_din,
        input  dout, dout_valid, clip, busy, drop
    );

    modport slave (
        input  cen, sample, din, gain_we, gain_addr, gain_din,
        output dout, dout_valid, clip, busy, drop
    );
endinterface

// File: rtl/jt12_mix_n.sv
// jt12_mix_n -- sequential N-channel mixer with per-channel gain.
//
// A sample strobe snapshots all channels, then one multiply-accumulate per
// cen-qualified edge sums snap[k]*gain[k]; a final edge scales by 1/16,
// saturates to WOUT bits and pulses dout_valid.
//
// Ports:
//   clk  clock
//   rst  synchronous active-high reset
//   bus  jt12_mix_n_if.slave (see interface file for signal list)
module jt12_mix_n #(
    parameter int NCH  = 4,
    parameter int WIN  = 16,
    parameter int GW   = 8,
    parameter int WOUT = 16
) (
    input  logic         clk,
    input  logic         rst,
    jt12_mix_n_if.slave  bus
);
    // Accumulator wide enough that NCH full-scale products can never overflow.
    localparam int AW = WIN + GW + $clog2(NCH + 1);
    localparam int PW = WIN + GW + 1;
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic signed [AW-1:0] SAT_HI = AW'(2**(WOUT-1) - 1);
    localparam logic signed [AW-1:0] SAT_LO = ~SAT_HI;

    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

    state_t                 state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic signed [AW-1:0]   acc_q, acc_d;
    logic signed [WIN-1:0]  snap_q [NCH];
    logic signed [WIN-1:0]  snap_d [NCH];
    logic [GW-1:0]          gain_q [NCH];
    logic signed [WOUT-1:0] dout_q, dout_d;
    logic                   valid_q, valid_d;
    logic                   clip_q, clip_d;
    logic                   drop_q, drop_d;

    logic                   busy;
    logic                   gain_hit;
    logic signed [PW-1:0]   prod;
    logic signed [AW-1:0]   shifted;

    assign busy     = (state_q != IDLE);
    assign gain_hit = bus.gain_we && (32'(bus.gain_addr) < NCH);

    always_comb begin
        // NOTE: every always_comb target gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        snap_d  = snap_q;
        dout_d  = dout_q;
        clip_d  = clip_q;
        valid_d = 1'b0;
        // A strobe while busy (including the OUT edge) is dropped, not queued.
        drop_d  = drop_q | (bus.cen & bus.sample & busy);

        // Gain is zero-extended so the product is signed x unsigned.
        prod    = snap_q[idx_q] * $signed({1'b0, gain_q[idx_q]});
        // Arithmetic shift floors toward minus infinity.
        shifted = acc_q >>> 4;

        if (bus.cen) begin
            case (state_q)
                IDLE: begin
                    if (bus.sample) begin
                        for (int k = 0; k < NCH; k++) begin
                            snap_d[k] = bus.din[k*WIN +: WIN];
                        end
                        acc_d   = '0;
                        idx_d   = '0;
                        state_d = ACC;
                    end
                end
                ACC: begin
                    acc_d = acc_q + AW'(prod);
                    idx_d = idx_q + 1'b1;
                    if (idx_q == IW'(NCH - 1)) begin
                        idx_d   = '0;
                        state_d = OUT;
                    end
                end
                OUT: begin
                    if (shifted > SAT_HI) begin
                        dout_d = WOUT'(SAT_HI);
                        clip_d = 1'b1;
                    end else if (shifted < SAT_LO) begin
                        dout_d = WOUT'(SAT_LO);
                        clip_d = 1'b1;
                    end else begin
                        dout_d = WOUT'(shifted);
                        clip_d = 1'b0;
                    end
                    valid_d = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            clip_q  <= 1'b0;
            drop_q  <= 1'b0;
            // NOTE: the gain bank is reset because its reset value (unity) is
            // architecturally visible; the snapshot bank is not, since it is
            // always rewritten before it is read.
            for (int k = 0; k < NCH; k++) begin
                gain_q[k] <= GW'(16);
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            clip_q  <= clip_d;
            drop_q  <= drop_d;
            // Gain writes ignore cen; the term being summed this edge
            // already read the old gain.
            if (gain_hit) begin
                gain_q[bus.gain_addr[IW-1:0]] <= bus.gain_din;
            end
        end
    end

    always_ff @(posedge clk) begin
        snap_q <= snap_d;
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = valid_q;
    assign bus.clip       = clip_q;
    assign bus.busy       = busy;
    assign bus.drop       = drop_q;
endmodule

// File: tb/tb_jt12_mix_n.sv
// tb_jt12_mix_n -- directed self-checking bench for jt12_mix_n (NCH=4,
// WIN=16, GW=8, WOUT=16). Inputs change 1 time unit after the rising edge;
// outputs are sampled at that same point, away from the edge.
module tb_jt12_mix_n;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    jt12_mix_n_if #(.NCH(4), .WIN(16), .GW(8), .WOUT(16)) bus ();

    jt12_mix_n #(.NCH(4), .WIN(16), .GW(8), .WOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Ticks until dout_valid is seen, bounded at 20 edges.
    task automatic wait_valid(output int n);
        n = 0;
        while (bus.dout_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic start_mix(input logic [63:0] d);
        bus.din    = d;
        bus.sample = 1'b1;
        tick();
        bus.sample = 1'b0;
    endtask

    task automatic gain_write(input logic [3:0] a, input logic [7:0] g);
        bus.gain_we   = 1'b1;
        bus.gain_addr = a;
        bus.gain_din  = g;
        tick();
        bus.gain_we   = 1'b0;
    endtask

    task automatic mix_check(input string tag, input logic [63:0] d,
                             input logic [15:0] exp_dout, input logic exp_clip);
        int n;
        start_mix(d);
        check({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
        wait_valid(n);
        check({tag, "_lat"}, n, 32'd5);
        check({tag, "_dout"}, {16'd0, bus.dout}, {16'd0, exp_dout});
        check({tag, "_clip"}, {31'd0, bus.clip}, {31'd0, exp_clip});
        tick();
        check({tag, "_pulse"}, {31'd0, bus.dout_valid}, 32'd0);
        check({tag, "_idle"}, {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        int n;
        int hi;
        logic cen_at;
        logic seen;

        rst           = 1'b1;
        bus.cen       = 1'b1;
        bus.sample    = 1'b0;
        bus.din       = '0;
        bus.gain_we   = 1'b0;
        bus.gain_addr = '0;
        bus.gain_din  = '0;
        tick();
        tick();
        check("rst_dout",  {16'd0, bus.dout}, 32'd0);
        check("rst_valid", {31'd0, bus.dout_valid}, 32'd0);
        check("rst_clip",  {31'd0, bus.clip}, 32'd0);
        check("rst_busy",  {31'd0, bus.busy}, 32'd0);
        check("rst_drop",  {31'd0, bus.drop}, 32'd0);
        rst = 1'b0;
        tick();

        // Basic unity mix and both saturation directions.
        mix_check("unity", {4{16'h1000}}, 16'h4000, 1'b0);
        mix_check("sat_pos", {16'h0000, 16'h0000, 16'h7FFF, 16'h7FFF}, 16'h7FFF, 1'b1);
        mix_check("sat_neg", {4{16'h8000}}, 16'h8000, 1'b1);

        // cen toggling: count cen-high edges after the accepting edge.
        bus.din    = {4{16'h0100}};
        bus.sample = 1'b1;
        bus.cen    = 1'b1;
        tick();
        bus.sample = 1'b0;
        hi     = 0;
        n      = 0;
        cen_at = 1'b0;
        while (n < 20) begin
            bus.cen = ~bus.cen;
            tick();
            n++;
            if (bus.cen) hi++;
            if (bus.dout_valid === 1'b1) begin
                cen_at = bus.cen;
                break;
            end
        end
        bus.cen = 1'b1;
        check("cen_hi_edges", hi, 32'd5);
        check("cen_valid_edge", {31'd0, cen_at}, 32'd1);
        check("cen_dout", {16'd0, bus.dout}, 32'h0400);
        tick();

        // Strobe while busy is ignored and sets drop.
        check("drop_pre", {31'd0, bus.drop}, 32'd0);
        start_mix({4{16'h1000}});
        tick();
        start_mix({4{16'h2000}});
        wait_valid(n);
        check("drop_lat", n + 2, 32'd5);
        check("drop_dout", {16'd0, bus.dout}, 32'h4000);
        check("drop_flag", {31'd0, bus.drop}, 32'd1);
        tick();

        // Out-of-range gain address is ignored.
        gain_write(4'd5, 8'h00);
        mix_check("addr5", {4{16'h1000}}, 16'h4000, 1'b0);

        // Gain written on the edge channel 0 is summed: old gain still used.
        start_mix({4{16'h1000}});
        bus.gain_we   = 1'b1;
        bus.gain_addr = 4'd0;
        bus.gain_din  = 8'h00;
        tick();
        bus.gain_we   = 1'b0;
        wait_valid(n);
        check("same_edge_lat", n + 1, 32'd5);
        check("same_edge_dout", {16'd0, bus.dout}, 32'h4000);
        tick();
        mix_check("next_mix", {4{16'h1000}}, 16'h3000, 1'b0);

        // Zero gain, then half gain.
        gain_write(4'd3, 8'h00);
        mix_check("gain3_zero", {16'h7FFF, 16'h0000, 16'h0000, 16'h0000}, 16'h0000, 1'b0);
        gain_write(4'd2, 8'h08);
        mix_check("gain2_half", {16'h0000, 16'h2000, 16'h0000, 16'h0000}, 16'h1000, 1'b0);

        // Reset mid-mix abandons it and restores defaults.
        start_mix({4{16'h1000}});
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", {31'd0, bus.busy}, 32'd0);
        check("midrst_dout", {16'd0, bus.dout}, 32'd0);
        check("midrst_drop", {31'd0, bus.drop}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            seen |= bus.dout_valid;
        end
        check("midrst_novalid", {31'd0, seen}, 32'd0);
        mix_check("gains_reset", {4{16'h1000}}, 16'h4000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
